// File: rtl/Config.sv
// Shared geometry, FSM encoding and row payload for the systolic output collector.
package Config;

  localparam int unsigned sys_cols   = 4;
  localparam int unsigned P_BITWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } collector_state_t;

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] row_data_t;

  typedef struct packed {
    logic      last;
    row_data_t data;
  } row_entry_t;

endpackage

// File: rtl/row_fifo.sv
// Power-of-two row buffer; an extra pointer bit separates full from empty.
module row_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full, the slot being written is the one popped in the same cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/systolic_output_collector.sv
// Deskews the array's bottom-row partial sums into aligned rows and buffers them per tile.
module systolic_output_collector
  import Config::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [15:0]                          tile_rows,
  input  logic                                 in_valid,
  input  logic [sys_cols-1:0][P_BITWIDTH-1:0]  of_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [sys_cols-1:0][P_BITWIDTH-1:0]  out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = $bits(row_entry_t);

  collector_state_t state;
  collector_state_t state_nxt;
  logic [15:0]      tile_rows_q;
  logic [15:0]      row_cnt;
  logic [sys_cols-2:0] vchain;
  row_data_t        aligned;
  logic             aligned_valid;
  logic             row_in;
  logic             push;
  logic             pop;
  logic             start_acc;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_empty_nxt;
  logic [CW-1:0]    fifo_count;
  row_entry_t       wentry;
  row_entry_t       rentry;

  // Column j lands j cycles late, so it is delayed sys_cols-1-j cycles to line up.
  for (genvar j = 0; j < sys_cols; j++) begin : g_col
    localparam int unsigned D = sys_cols - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned[j] = of_data[j];
    end else begin : g_pipe
      logic [P_BITWIDTH-1:0] pipe [D];
      always_ff @(posedge clk) begin
        pipe[0] <= of_data[j];
        for (int unsigned k = 1; k < D; k++) pipe[k] <= pipe[k-1];
      end
      assign aligned[j] = pipe[D-1];
    end
  end

  assign aligned_valid  = vchain[sys_cols-2];
  assign row_in         = aligned_valid && (state == COLLECT);
  assign pop            = out_valid && out_ready;
  assign push           = row_in && (!fifo_full || pop);
  assign fifo_empty_nxt = fifo_empty || ((fifo_count == CW'(1)) && pop);

  assign wentry.last = (row_cnt == tile_rows_q - 16'd1);
  assign wentry.data = aligned;

  row_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rentry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = rentry.data;
  assign out_last  = !fifo_empty && rentry.last;

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (tile_rows != 16'd0)) begin
          start_acc = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (row_in && (row_cnt + 16'd1 == tile_rows_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty_nxt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tile_rows_q <= '0;
      row_cnt     <= '0;
      vchain      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == DRAIN) && (state_nxt == IDLE);
      if (start_acc) begin
        tile_rows_q <= tile_rows;
        row_cnt     <= '0;
        overflow    <= 1'b0;
        vchain      <= '0;
      end else begin
        vchain <= {vchain[sys_cols-3:0], in_valid && (state == COLLECT)};
        if (row_in)          row_cnt  <= row_cnt + 16'd1;
        if (row_in && !push) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Self-checking bench: directed vector table, directed corner sequences and a randomized queue-model run.
module tb_systolic_output_collector;
  import Config::*;

  localparam int unsigned DEPTH = 4;

  logic                                clk = 1'b0;
  logic                                rst;
  logic                                start;
  logic [15:0]                         tile_rows;
  logic                                in_valid;
  logic [sys_cols-1:0][P_BITWIDTH-1:0] of_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [sys_cols-1:0][P_BITWIDTH-1:0] out_data;
  logic                                out_last;
  logic                                busy;
  logic                                done;
  logic                                overflow;

  systolic_output_collector #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tile_rows (tile_rows),
    .in_valid  (in_valid),
    .of_data   (of_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef logic [3:0][31:0] row_t;

  typedef struct {
    bit          st;
    logic [15:0] tr;
    bit          iv;
    row_t        d;
    bit          e_busy;
    bit          e_valid;
    bit          e_last;
    bit          e_done;
    row_t        e_data;
  } vec_t;

  typedef struct { row_t data; logic last; } ent_t;
  typedef struct { int due; row_t data; } pend_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 8;
  row_t  hist [8];
  ent_t  got [$];

  // Reference model: output queue, in-flight rows and tile bookkeeping.
  ent_t  mq [$];
  pend_t pq [$];
  int    m_phase;
  int    m_tr;
  int    m_cnt;
  bit    m_ovf;
  bit    m_done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic row_t row4(input int c3, input int c2, input int c1, input int c0);
    row_t r;
    r[3] = 32'(c3); r[2] = 32'(c2); r[1] = 32'(c1); r[0] = 32'(c0);
    return r;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    for (int j = 0; j < 4; j++) r[j] = $urandom;
    return r;
  endfunction

  function automatic row_t srow(input int k);
    row_t r;
    for (int j = 0; j < 4; j++) r[j] = 32'(k * 16 + j);
    return r;
  endfunction

  function automatic vec_t mkv(input bit st, input int tr, input bit iv, input row_t d,
                               input bit eb, input bit ev, input bit el, input bit ed, input row_t edata);
    vec_t v;
    v.st = st; v.tr = 16'(tr); v.iv = iv; v.d = d;
    v.e_busy = eb; v.e_valid = ev; v.e_last = el; v.e_done = ed; v.e_data = edata;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete(); pq.delete();
    m_phase = 0; m_tr = 0; m_cnt = 0; m_ovf = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_compare(input bit rdy);
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("busy",      128'(busy),      128'(m_phase != 0));
    chk("done",      128'(done),      128'(m_done));
    chk("overflow",  128'(overflow),  128'(m_ovf));
    if (mq.size() > 0) begin
      chk("out_data", 128'(out_data), 128'(mq[0].data));
      chk("out_last", 128'(out_last), 128'(mq[0].last));
    end
    if (out_valid && rdy) got.push_back('{out_data, out_last});
  endtask

  task automatic model_step(input bit st, input logic [15:0] tr, input bit iv, input bit rdy);
    bit    pop;
    bit    do_push;
    int    old_phase;
    pend_t pr;
    ent_t  e;
    pop       = (mq.size() > 0) && rdy;
    old_phase = m_phase;
    do_push   = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      pr = pq.pop_front();
      if (old_phase == 1) begin
        e.data = pr.data;
        e.last = (m_cnt == m_tr - 1);
        m_cnt++;
        if (mq.size() < DEPTH || pop) do_push = 1'b1;
        else m_ovf = 1'b1;
        if (m_cnt == m_tr) m_phase = 2;
      end
    end
    if (iv && old_phase == 1) pq.push_back('{cyc + 3, hist[cyc % 8]});
    if (pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    m_done = 1'b0;
    if (old_phase == 2 && mq.size() == 0) begin
      m_phase = 0;
      m_done  = 1'b1;
    end
    if (old_phase == 0 && st && tr != 16'd0) begin
      m_phase = 1; m_tr = int'(tr); m_cnt = 0; m_ovf = 1'b0;
      pq.delete();
    end
  endtask

  task automatic cycle(input bit st, input logic [15:0] tr, input bit iv, input bit rdy, input row_t row);
    hist[cyc % 8] = row;
    start = st; tile_rows = tr; in_valid = iv; out_ready = rdy;
    for (int j = 0; j < 4; j++) of_data[j] = hist[(cyc - j) % 8][j];
    model_compare(rdy);
    model_step(st, tr, iv, rdy);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit rnd_ready);
    int n;
    n = 0;
    while (m_phase != 0 && n < 400) begin
      cycle(1'b0, 16'd0, 1'b0, rnd_ready ? 1'($urandom % 2) : 1'b1, rnd_row());
      n++;
    end
    checks++;
    if (m_phase != 0) begin
      errors++;
      $display("FAIL wait_idle: tile still active after %0d cycles, required idle", n);
    end
  endtask

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 8; i++) hist[i] = rnd_row();
    model_reset();
    rst = 1'b0; start = 1'b0; tile_rows = '0; in_valid = 1'b0; out_ready = 1'b1; of_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_done",      128'(done),      128'(0));
    chk("rst_overflow",  128'(overflow),  128'(0));
    chk("rst_out_last",  128'(out_last),  128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single row with hand-computed timing, then ignored start/in_valid in IDLE.
    tbl[0]  = mkv(1, 1, 0, '0,               0, 0, 0, 0, '0);
    tbl[1]  = mkv(0, 0, 0, '0,               1, 0, 0, 0, '0);
    tbl[2]  = mkv(0, 0, 1, row4(0, 0, 0, 1), 1, 0, 0, 0, '0);
    tbl[3]  = mkv(0, 0, 0, row4(0, 0, 2, 0), 1, 0, 0, 0, '0);
    tbl[4]  = mkv(0, 0, 0, row4(0, 3, 0, 0), 1, 0, 0, 0, '0);
    tbl[5]  = mkv(0, 0, 0, row4(4, 0, 0, 0), 1, 0, 0, 0, '0);
    tbl[6]  = mkv(0, 0, 0, '0,               1, 1, 1, 0, row4(4, 3, 2, 1));
    tbl[7]  = mkv(0, 0, 0, '0,               0, 0, 0, 1, '0);
    tbl[8]  = mkv(1, 0, 0, '0,               0, 0, 0, 0, '0);
    tbl[9]  = mkv(0, 0, 1, row4(9, 9, 9, 9), 0, 0, 0, 0, '0);
    tbl[10] = mkv(0, 0, 1, row4(9, 9, 9, 9), 0, 0, 0, 0, '0);
    tbl[11] = mkv(0, 0, 0, row4(9, 9, 9, 9), 0, 0, 0, 0, '0);
    tbl[12] = mkv(0, 0, 0, row4(9, 9, 9, 9), 0, 0, 0, 0, '0);
    tbl[13] = mkv(0, 0, 0, '0,               0, 0, 0, 0, '0);
    tbl[14] = mkv(0, 0, 0, '0,               0, 0, 0, 0, '0);
    for (int i = 0; i < 15; i++) begin
      start = tbl[i].st; tile_rows = tbl[i].tr; in_valid = tbl[i].iv; of_data = tbl[i].d; out_ready = 1'b1;
      chk($sformatf("tbl%0d_busy", i),      128'(busy),      128'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_done", i),      128'(done),      128'(tbl[i].e_done));
      chk($sformatf("tbl%0d_overflow", i),  128'(overflow),  128'(0));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_out_data", i), 128'(out_data), 128'(tbl[i].e_data));
        chk($sformatf("tbl%0d_out_last", i), 128'(out_last), 128'(tbl[i].e_last));
      end
      @(posedge clk);
      #1;
    end

    // Streaming: eight back-to-back rows.
    got.delete();
    cycle(1'b1, 16'd8, 1'b0, 1'b1, rnd_row());
    for (int k = 0; k < 8; k++) cycle(1'b0, 16'd0, 1'b1, 1'b1, srow(k));
    wait_idle(1'b0);
    chk("stream_count", 128'(got.size()), 128'(8));
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      chk($sformatf("stream_row%0d", k),  128'(got[k].data), 128'(srow(k)));
      chk($sformatf("stream_last%0d", k), 128'(got[k].last), 128'(k == 7));
    end
    chk("stream_overflow", 128'(overflow), 128'(0));

    // Backpressure: six rows into a four-deep buffer with no consumer.
    got.delete();
    cycle(1'b1, 16'd6, 1'b0, 1'b0, rnd_row());
    for (int k = 0; k < 6; k++) cycle(1'b0, 16'd0, 1'b1, 1'b0, srow(k + 32));
    for (int k = 0; k < 6; k++) cycle(1'b0, 16'd0, 1'b0, 1'b0, rnd_row());
    chk("bp_overflow_set", 128'(overflow), 128'(1));
    chk("bp_busy_held",    128'(busy),     128'(1));
    wait_idle(1'b0);
    chk("bp_count", 128'(got.size()), 128'(4));
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      chk($sformatf("bp_row%0d", k),  128'(got[k].data), 128'(srow(k + 32)));
      chk($sformatf("bp_last%0d", k), 128'(got[k].last), 128'(0));
    end
    chk("bp_overflow_sticky", 128'(overflow), 128'(1));

    // Full buffer, pop in the very cycle the fifth row aligns.
    got.delete();
    cycle(1'b1, 16'd5, 1'b0, 1'b0, rnd_row());
    for (int i = 1; i <= 12; i++)
      cycle(1'b0, 16'd0, i <= 5, (i == 8) || (i >= 10), srow(i + 64));
    wait_idle(1'b0);
    chk("full_pop_overflow", 128'(overflow), 128'(0));
    chk("full_pop_count",    128'(got.size()), 128'(5));
    if (got.size() == 5) chk("full_pop_last", 128'(got[4].last), 128'(1));

    // Reset while two rows are buffered mid-COLLECT.
    got.delete();
    cycle(1'b1, 16'd5, 1'b0, 1'b0, rnd_row());
    cycle(1'b0, 16'd0, 1'b1, 1'b0, rnd_row());
    cycle(1'b0, 16'd0, 1'b1, 1'b0, rnd_row());
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'd0, 1'b0, 1'b0, rnd_row());
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_busy",      128'(busy),      128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_overflow",  128'(overflow),  128'(0));
    rst = 1'b1;
    cyc++;
    cycle(1'b1, 16'd1, 1'b0, 1'b1, rnd_row());
    cycle(1'b0, 16'd0, 1'b1, 1'b1, srow(99));
    wait_idle(1'b0);
    chk("midrst_count", 128'(got.size()), 128'(1));
    if (got.size() == 1) begin
      chk("midrst_row",  128'(got[0].data), 128'(srow(99)));
      chk("midrst_last", 128'(got[0].last), 128'(1));
    end

    // Random tiles with random gaps, backpressure and stray start/in_valid.
    for (int t = 0; t < 25; t++) begin
      int n_idle;
      n_idle = int'($urandom_range(0, 3));
      for (int i = 0; i < n_idle; i++)
        cycle(1'($urandom % 4 == 0), 16'd0, 1'($urandom % 2), 1'($urandom % 2), rnd_row());
      cycle(1'b1, 16'($urandom_range(1, 10)), 1'b0, 1'($urandom % 2), rnd_row());
      for (int i = 0; i < 400 && m_phase == 1; i++)
        cycle(1'($urandom % 8 == 0), 16'($urandom_range(0, 10)), ($urandom % 10) < 6,
              1'($urandom % 2), rnd_row());
      wait_idle(1'b1);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'd0, 1'b0, 1'b1, rnd_row());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_output_collector.md
SYSTOLIC_OUTPUT_COLLECTOR -- requirements
Module: systolic_output_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, aligned-row buffer depth (power of 2, at least 2).
REQ-002 SHALL take sys_cols and P_BITWIDTH from package Config; it SHALL NOT redeclare them locally.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, single-cycle pulse that begins a tile.
REQ-006 SHALL have port tile_rows, input, 16 bits, number of result rows in the tile; latched on an accepted start.
REQ-007 SHALL have port in_valid, input, 1 bit, high in the cycle that of_data[0] carries a valid row result.
REQ-008 SHALL have port of_data, input, [sys_cols-1:0][P_BITWIDTH-1:0], skewed array bottom-row partial sums.
REQ-009 SHALL have port out_valid, output, 1 bit, aligned row available.
REQ-010 SHALL have port out_ready, input, 1 bit, consumer accepts the row.
REQ-011 SHALL have port out_data, output, [sys_cols-1:0][P_BITWIDTH-1:0], column-aligned row.
REQ-012 SHALL have port out_last, output, 1 bit, qualifies the final row of the tile.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse when the tile is fully drained.
REQ-015 SHALL have port overflow, output, 1 bit, sticky flag set when a row is dropped.

Function
REQ-016 Skew model: column j of a row arrives j cycles after in_valid.
REQ-017 Deskew: column j SHALL pass through sys_cols-1-j register stages; column sys_cols-1 has zero stages.
REQ-018 A valid shift chain sys_cols-1 deep SHALL carry in_valid to the aligned point at cycle t+sys_cols-1.
REQ-019 FSM states SHALL be IDLE, COLLECT and DRAIN.
REQ-020 IDLE: start with tile_rows!=0 SHALL latch tile_rows, clear row_cnt and overflow, and go to COLLECT.
REQ-021 IDLE: start with tile_rows==0 SHALL be ignored.
REQ-022 start SHALL be ignored in COLLECT and DRAIN.
REQ-023 in_valid SHALL be ignored in IDLE; the valid chain is cleared on entry to COLLECT.
REQ-024 COLLECT: each aligned-valid row SHALL increment row_cnt (16 bits) whether pushed or dropped.
REQ-025 COLLECT: when row_cnt reaches tile_rows the FSM SHALL go to DRAIN; in_valid is ignored after that.
REQ-026 Push rule: an aligned row SHALL be written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-027 Dropped row: if the push rule fails, the row SHALL be dropped and overflow set; the array is never stalled.
REQ-028 Each FIFO entry SHALL store a last bit equal to (row index == tile_rows-1).
REQ-029 Latency: with an empty FIFO, out_valid SHALL rise in cycle t+sys_cols, where t is the in_valid cycle.
REQ-030 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 A pop SHALL occur iff out_valid and out_ready are both high.
REQ-032 DRAIN: when the FIFO is empty, the FSM SHALL go to IDLE and pulse done for one cycle.
REQ-033 Pointer wrap-around SHALL be modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-034 overflow SHALL be cleared only by reset or by an accepted start.

Reset
REQ-035 Asserting rst SHALL immediately, including mid-tile, return the FSM to IDLE.
REQ-036 Asserting rst SHALL empty the FIFO and clear the valid chain and row_cnt.
REQ-037 Asserting rst SHALL drive out_valid=0, out_last=0, busy=0, done=0 and overflow=0.
REQ-038 Deskew data registers need no reset; out_data is don't-care while out_valid=0.

Structure
REQ-039 sys_cols, P_BITWIDTH and the FSM state enum (collector_state_t) SHALL live in package Config.
REQ-040 The FIFO SHALL be one sub-module, row_fifo, parameterised by width and depth; deskew and FSM stay in the top level.

Verification (sys_cols=4, P_BITWIDTH=32, FIFO_DEPTH=4)
REQ-041 Single row: start with tile_rows=1, in_valid at t=10, of_data[j]=j+1 at t=10+j, out_ready=1 -> out_valid at t=14, out_data={4,3,2,1}, out_last=1, done at t=15.
REQ-042 Streaming: tile_rows=8, in_valid on 8 consecutive cycles, row k columns = k*16+j -> 8 aligned rows in order, out_last only on row 7, overflow=0.
REQ-043 Backpressure: tile_rows=6, out_ready=0 throughout -> 4 rows buffered, rows 4 and 5 dropped, overflow=1; then out_ready=1 -> rows 0..3 out, none with out_last, done.
REQ-044 Full FIFO with same-cycle pop: FIFO full, out_ready=1 in the cycle an aligned row arrives -> row accepted, overflow stays 0.
REQ-045 Reset mid-operation: rst asserted during COLLECT with 2 rows buffered -> next cycle busy=0 and out_valid=0; a new tile with tile_rows=1 completes normally.
REQ-046 Ignored inputs: start with tile_rows=0 -> busy stays 0; in_valid pulses in IDLE -> no out_valid.
